// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Memory-stage data-access unit. Converts the M-stage memory controls into
//   a single request on a sram-like bus (req / addr_ok / data_ok), returns
//   load data to the M/W path and holds the pipeline via stall_req until the
//   access has completed.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   memenM/memwriteM  M-stage access enable / store select
//   addrM/wdataM      byte address / lane-replicated store data
//   sizeM             0 byte, 1 half, 2 word
//   flushM            M-stage instruction cancelled
//   pipe_stall        pipeline held by another source
//   stall_req         stall request to the hazard unit
//   rdataM            load data for the M-stage instruction
//   data_*            sram-like bus (req, wr, size, addr, wdata out;
//                     addr_ok, data_ok, rdata in)
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic [1:0]  sizeM,
  input  logic        flushM,
  input  logic        pipe_stall,
  output logic        stall_req,
  output logic [31:0] rdataM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        cancel_reg, cancel_next;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        issue;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cancel_reg <= 1'b0;
      wr_reg     <= 1'b0;
      size_reg   <= 2'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cancel_reg <= cancel_next;
      // Hold the request fields so the bus sees them stable until addr_ok,
      // whatever the M-stage inputs do meanwhile.
      if (issue) begin
        wr_reg    <= memwriteM;
        size_reg  <= sizeM;
        addr_reg  <= addrM;
        wdata_reg <= wdataM;
      end
      if (state_reg == WAIT && data_data_ok) begin
        rdata_reg <= data_rdata;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cancel_next = cancel_reg;
    issue       = 1'b0;
    data_req    = 1'b0;
    data_wr     = wr_reg;
    data_size   = size_reg;
    data_addr   = addr_reg;
    data_wdata  = wdata_reg;
    stall_req   = 1'b0;
    rdataM      = rdata_reg;

    case (state_reg)
      IDLE: begin
        issue     = memenM & ~flushM;
        data_req  = issue;
        stall_req = issue;
        if (issue) begin
          // First request cycle goes straight from the M inputs so a fast
          // bus can accept it with no extra latency.
          data_wr    = memwriteM;
          data_size  = sizeM;
          data_addr  = addrM;
          data_wdata = wdataM;
          state_next = data_addr_ok ? WAIT : REQ;
        end else begin
          // Bus fields are only meaningful alongside data_req; park at zero.
          data_wr    = 1'b0;
          data_size  = 2'd0;
          data_addr  = 32'd0;
          data_wdata = 32'd0;
        end
      end

      REQ: begin
        // A raised request cannot be withdrawn; a flush only marks it so
        // the eventual data is thrown away.
        data_req  = 1'b1;
        stall_req = ~cancel_reg | memenM;
        if (flushM) begin
          cancel_next = 1'b1;
        end
        if (data_addr_ok) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        // A cancelled access still blocks a newly arrived memory
        // instruction until the bus is free again.
        stall_req = ~data_data_ok | (cancel_reg & memenM);
        if (data_data_ok) begin
          cancel_next = 1'b0;
          if (!cancel_reg) begin
            rdataM = data_rdata;
          end
          if (cancel_reg) begin
            state_next = IDLE;
          end else begin
            state_next = pipe_stall ? DONE : IDLE;
          end
        end else if (flushM) begin
          cancel_next = 1'b1;
        end
      end

      DONE: begin
        // Access finished but the instruction is held elsewhere; keep
        // presenting the captured data without re-issuing.
        if (!pipe_stall || flushM) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge
//   Self-checking bench for data_sram_bridge: directed scenarios followed by
//   randomized loads/stores against a bench-side memory model.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memenM = 1'b0;
  logic        memwriteM = 1'b0;
  logic [31:0] addrM = 32'd0;
  logic [31:0] wdataM = 32'd0;
  logic [1:0]  sizeM = 2'd0;
  logic        flushM = 1'b0;
  logic        pipe_stall = 1'b0;
  logic        stall_req;
  logic [31:0] rdataM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .memenM       (memenM),
    .memwriteM    (memwriteM),
    .addrM        (addrM),
    .wdataM       (wdataM),
    .sizeM        (sizeM),
    .flushM       (flushM),
    .pipe_stall   (pipe_stall),
    .stall_req    (stall_req),
    .rdataM       (rdataM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    memenM = 1'b0; memwriteM = 1'b0; addrM = 32'd0; wdataM = 32'd0; sizeM = 2'd0;
    flushM = 1'b0; pipe_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic drive_load(input logic [31:0] a);
    memenM = 1'b1; memwriteM = 1'b0; addrM = a; wdataM = 32'd0; sizeM = 2'd2; flushM = 1'b0;
  endtask

  // Sub-word store semantics: replace only the addressed lanes of a word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0:    r[{a[1:0], 3'b000} +: 8] = wd[{a[1:0], 3'b000} +: 8];
      2'd1:    r[{a[1], 4'b0000} +: 16] = wd[{a[1], 4'b0000} +: 16];
      default: r = wd;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_data_req: got %b expected 0", data_req); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall_req: got %b expected 0", stall_req); end
    checks++; if (data_wr !== 1'b0) begin errors++; $display("FAIL reset_data_wr: got %b expected 0", data_wr); end
    checks++; if (data_size !== 2'd0) begin errors++; $display("FAIL reset_data_size: got %0d expected 0", data_size); end
    checks++; if (data_addr !== 32'd0) begin errors++; $display("FAIL reset_data_addr: got %h expected 0", data_addr); end
    checks++; if (data_wdata !== 32'd0) begin errors++; $display("FAIL reset_data_wdata: got %h expected 0", data_wdata); end
    checks++; if (rdataM !== 32'd0) begin errors++; $display("FAIL reset_rdataM: got %h expected 0", rdataM); end
    rst = 1'b1;
    next_cycle();
    $display("test_reset done");
  endtask

  task automatic test_min_latency();
    drive_load(32'h8000_1000); data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL min_stall_c0: got %b expected 1", stall_req); end
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL min_req_c0: got %b expected 1", data_req); end
    checks++; if (data_addr !== 32'h8000_1000) begin errors++; $display("FAIL min_addr_c0: got %h expected 80001000", data_addr); end
    checks++; if ({data_wr, data_size} !== 3'b010) begin errors++; $display("FAIL min_wr_size_c0: got %b expected 010", {data_wr, data_size}); end
    next_cycle(); data_addr_ok = 1'b0;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL min_stall_c1: got %b expected 1", stall_req); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL min_req_c1: got %b expected 0", data_req); end
    next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL min_stall_c2: got %b expected 0", stall_req); end
    checks++; if (rdataM !== 32'h1234_5678) begin errors++; $display("FAIL min_rdata_c2: got %h expected 12345678", rdataM); end
    // Back in IDLE: a following load is requested at once.
    next_cycle(); data_data_ok = 1'b0; data_rdata = 32'd0; drive_load(32'h8000_1004); data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL min_idle_req_c3: got %b expected 1", data_req); end
    checks++; if (data_addr !== 32'h8000_1004) begin errors++; $display("FAIL min_idle_addr_c3: got %h expected 80001004", data_addr); end
    next_cycle(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h9ABC_DEF0;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL min_stall_c4: got %b expected 0", stall_req); end
    checks++; if (rdataM !== 32'h9ABC_DEF0) begin errors++; $display("FAIL min_rdata_c4: got %h expected 9abcdef0", rdataM); end
    next_cycle(); drive_idle(); last_load = 32'h9ABC_DEF0;
    $display("test_min_latency done");
  endtask

  task automatic test_delayed_addr_ok();
    drive_load(32'h8000_1000);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) addrM = 32'd0;
      data_addr_ok = (c == 3);
      @(negedge clk);
      checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL dly_req c%0d: got %b expected 1", c, data_req); end
      checks++; if (data_addr !== 32'h8000_1000) begin errors++; $display("FAIL dly_addr c%0d: got %h expected 80001000", c, data_addr); end
      checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL dly_stall c%0d: got %b expected 1", c, stall_req); end
      next_cycle();
    end
    data_addr_ok = 1'b0; addrM = 32'h8000_1000; data_data_ok = 1'b1; data_rdata = 32'h0BAD_BEEF;
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL dly_req_done: got %b expected 0", data_req); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL dly_stall_done: got %b expected 0", stall_req); end
    checks++; if (rdataM !== 32'h0BAD_BEEF) begin errors++; $display("FAIL dly_rdata: got %h expected 0badbeef", rdataM); end
    next_cycle(); drive_idle(); last_load = 32'h0BAD_BEEF;
    $display("test_delayed_addr_ok done");
  endtask

  task automatic test_external_stall();
    drive_load(32'h8000_1008); data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL xst_stall_c0: got %b expected 1", stall_req); end
    next_cycle(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; pipe_stall = 1'b1;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL xst_stall_ok: got %b expected 0", stall_req); end
    checks++; if (rdataM !== 32'hCAFE_F00D) begin errors++; $display("FAIL xst_rdata_ok: got %h expected cafef00d", rdataM); end
    for (int c = 0; c < 4; c++) begin
      next_cycle(); data_data_ok = 1'b0; data_rdata = 32'h1111_1111;
      pipe_stall = (c < 3);
      @(negedge clk);
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL xst_stall_done c%0d: got %b expected 0", c, stall_req); end
      checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL xst_req_done c%0d: got %b expected 0", c, data_req); end
      checks++; if (rdataM !== 32'hCAFE_F00D) begin errors++; $display("FAIL xst_rdata_done c%0d: got %h expected cafef00d", c, rdataM); end
    end
    next_cycle(); drive_load(32'h8000_100C); data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL xst_idle_req: got %b expected 1", data_req); end
    next_cycle(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h600D_F00D;
    @(negedge clk);
    checks++; if (rdataM !== 32'h600D_F00D) begin errors++; $display("FAIL xst_rdata_next: got %h expected 600df00d", rdataM); end
    next_cycle(); drive_idle(); last_load = 32'h600D_F00D;
    $display("test_external_stall done");
  endtask

  task automatic test_flush_wait();
    drive_load(32'h8000_3000); data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fw_stall_c0: got %b expected 1", stall_req); end
    next_cycle(); data_addr_ok = 1'b0; flushM = 1'b1;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fw_stall_c1: got %b expected 1", stall_req); end
    next_cycle(); drive_load(32'h8000_2000);
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL fw_req_c2: got %b expected 0", data_req); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fw_stall_c2: got %b expected 1", stall_req); end
    next_cycle(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL fw_req_c3: got %b expected 0", data_req); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fw_stall_c3: got %b expected 1", stall_req); end
    checks++; if (rdataM !== last_load) begin errors++; $display("FAIL fw_rdata_c3: got %h expected %h", rdataM, last_load); end
    next_cycle(); data_data_ok = 1'b0; data_rdata = 32'd0; data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL fw_req_c4: got %b expected 1", data_req); end
    checks++; if (data_addr !== 32'h8000_2000) begin errors++; $display("FAIL fw_addr_c4: got %h expected 80002000", data_addr); end
    next_cycle(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL fw_stall_c5: got %b expected 0", stall_req); end
    checks++; if (rdataM !== 32'h5555_AAAA) begin errors++; $display("FAIL fw_rdata_c5: got %h expected 5555aaaa", rdataM); end
    next_cycle(); drive_idle(); last_load = 32'h5555_AAAA;
    $display("test_flush_wait done");
  endtask

  task automatic test_flush_req();
    drive_load(32'h8000_4000);
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL fr_req_c0: got %b expected 1", data_req); end
    next_cycle(); flushM = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL fr_req_c1: got %b expected 1", data_req); end
    checks++; if (data_addr !== 32'h8000_4000) begin errors++; $display("FAIL fr_addr_c1: got %h expected 80004000", data_addr); end
    next_cycle(); drive_idle(); data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL fr_req_c2: got %b expected 1", data_req); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL fr_stall_c2: got %b expected 0", stall_req); end
    next_cycle(); data_addr_ok = 1'b0;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL fr_stall_c3: got %b expected 1", stall_req); end
    next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h7777_0000;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL fr_stall_c4: got %b expected 0", stall_req); end
    next_cycle(); drive_idle();
    $display("test_flush_req done");
  endtask

  task automatic test_byte_store();
    memenM = 1'b1; memwriteM = 1'b1; sizeM = 2'd0; addrM = 32'h8000_0003; wdataM = 32'hABAB_ABAB;
    data_addr_ok = 1'b1;
    @(negedge clk);
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL st_req: got %b expected 1", data_req); end
    checks++; if (data_wr !== 1'b1) begin errors++; $display("FAIL st_wr: got %b expected 1", data_wr); end
    checks++; if (data_size !== 2'd0) begin errors++; $display("FAIL st_size: got %0d expected 0", data_size); end
    checks++; if (data_addr !== 32'h8000_0003) begin errors++; $display("FAIL st_addr: got %h expected 80000003", data_addr); end
    checks++; if (data_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL st_wdata: got %h expected abababab", data_wdata); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL st_stall_c0: got %b expected 1", stall_req); end
    next_cycle(); data_addr_ok = 1'b0;
    @(negedge clk);
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL st_stall_c1: got %b expected 1", stall_req); end
    next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL st_stall_ok: got %b expected 0", stall_req); end
    next_cycle(); drive_idle();
    $display("test_byte_store done");
  endtask

  task automatic test_reset_mid();
    drive_load(32'h8000_5000); data_addr_ok = 1'b1;
    @(negedge clk);
    next_cycle(); data_addr_ok = 1'b0; rst = 1'b0;
    @(negedge clk);
    next_cycle(); rst = 1'b1; drive_idle();
    @(negedge clk);
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b expected 0", data_req); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rm_stall: got %b expected 0", stall_req); end
    checks++; if (rdataM !== 32'd0) begin errors++; $display("FAIL rm_rdata: got %h expected 0", rdataM); end
    // The abandoned transaction's late data_ok must be ignored.
    next_cycle(); data_data_ok = 1'b1; data_rdata = 32'h3333_3333;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rm_stray_stall: got %b expected 0", stall_req); end
    next_cycle(); drive_idle();
    @(negedge clk);
    checks++; if (rdataM !== 32'd0) begin errors++; $display("FAIL rm_stray_rdata: got %h expected 0", rdataM); end
    next_cycle();
    $display("test_reset_mid done");
  endtask

  task automatic test_random(input int n);
    logic [31:0] ref_mem [16];
    logic [31:0] bus_mem [16];
    logic [31:0] a, wd, exp_rd;
    logic [31:0] acc_addr, acc_wdata;
    logic [1:0]  sz, acc_size;
    logic        wr, acc_wr;
    int idx, off, d1, d2, ps, gap;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    for (int t = 0; t < n; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive_idle();
        data_data_ok = 1'($urandom_range(0, 1));
        data_rdata = $urandom;
        @(negedge clk);
        checks++; if ({data_req, stall_req} !== 2'b00) begin errors++; $display("FAIL rnd_gap t%0d: got req/stall %b expected 00", t, {data_req, stall_req}); end
        next_cycle();
      end
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 2));
      idx = $urandom_range(0, 15);
      off = (sz == 2'd0) ? $urandom_range(0, 3) : (sz == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
      a   = 32'h8000_0000 | 32'(idx << 2) | 32'(off);
      wd  = $urandom;
      if (sz == 2'd0) wd = {4{wd[7:0]}};
      else if (sz == 2'd1) wd = {2{wd[15:0]}};
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(1, 3);
      ps = $urandom_range(0, 2);
      exp_rd = ref_mem[idx];
      acc_addr = 32'd0; acc_wdata = 32'd0; acc_size = 2'd0; acc_wr = 1'b0;
      $display("txn %0d: %s size=%0d addr=%h wdata=%h addr_ok+%0d data_ok+%0d hold=%0d",
               t, wr ? "store" : "load", sz, a, wd, d1, d2, ps);
      for (int c = 0; c <= d1 + d2 + ps; c++) begin
        memenM = 1'b1; flushM = 1'b0;
        if (c > 0 && c <= d1) begin
          memwriteM = 1'($urandom); sizeM = 2'($urandom); addrM = $urandom; wdataM = $urandom;
        end else begin
          memwriteM = wr; sizeM = sz; addrM = a; wdataM = wd;
        end
        data_addr_ok = (c == d1);
        data_data_ok = (c == d1 + d2) || (c > d1 + d2 && $urandom_range(0, 1) == 1);
        data_rdata   = (c == d1 + d2) ? bus_mem[acc_addr[5:2]] : $urandom;
        pipe_stall   = (c >= d1 + d2) && (c < d1 + d2 + ps);
        @(negedge clk);
        if (c == d1) begin
          acc_addr = data_addr; acc_wdata = data_wdata; acc_size = data_size; acc_wr = data_wr;
        end
        checks++; if (stall_req !== (c < d1 + d2)) begin errors++; $display("FAIL rnd_stall t%0d c%0d: got %b expected %b", t, c, stall_req, (c < d1 + d2)); end
        checks++; if (data_req !== (c <= d1)) begin errors++; $display("FAIL rnd_req t%0d c%0d: got %b expected %b", t, c, data_req, (c <= d1)); end
        if (c <= d1) begin
          checks++; if ({data_wr, data_size, data_addr, data_wdata} !== {wr, sz, a, wd}) begin errors++;
            $display("FAIL rnd_fields t%0d c%0d: got wr=%b size=%0d addr=%h wdata=%h expected wr=%b size=%0d addr=%h wdata=%h",
                     t, c, data_wr, data_size, data_addr, data_wdata, wr, sz, a, wd); end
        end
        if (!wr && c >= d1 + d2) begin
          checks++; if (rdataM !== exp_rd) begin errors++; $display("FAIL rnd_rdata t%0d c%0d: got %h expected %h", t, c, rdataM, exp_rd); end
        end
        next_cycle();
      end
      if (wr) begin
        ref_mem[idx] = merge(ref_mem[idx], a, sz, wd);
        if (acc_wr) bus_mem[acc_addr[5:2]] = merge(bus_mem[acc_addr[5:2]], acc_addr, acc_size, acc_wdata);
      end
      drive_idle();
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_delayed_addr_ok();
    test_external_stall();
    test_flush_wait();
    test_flush_req();
    test_byte_store();
    test_reset_mid();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
